// File: rtl/memory_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and a
// variable-latency data memory.
interface memory_access_if;
  logic        req;
  logic        we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        ack;
  logic        err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/memory_access.sv
// Y86-64 memory stage: classifies the instruction, performs at most one
// data-memory access over req/ack with timeout, and keeps a sticky status.
module memory_access #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [3:0]             icode_i,
  input  logic                   instr_valid_i,
  input  logic                   imem_error_i,
  input  logic [63:0]            vale_i,
  input  logic [63:0]            vala_i,
  input  logic [63:0]            valp_i,
  output logic [63:0]            valm_o,
  output logic [2:0]             stat_o,
  output logic                   busy_o,
  output logic                   done_o,
  memory_access_if.master        dmem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [2:0]    stat_q, stat_d;
  logic [63:0]   valm_q, valm_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, busy_q, done_q;

  logic          acc_s;
  logic          acc_we_s;
  logic [63:0]   acc_addr_s;
  logic [63:0]   acc_wdata_s;

  // Access decode per icode: stack ops (ret/popq) address through valA.
  always_comb begin
    acc_s       = 1'b0;
    acc_we_s    = 1'b0;
    acc_addr_s  = vale_i;
    acc_wdata_s = vala_i;
    case (icode_i)
      4'h4: begin acc_s = 1'b1; acc_we_s = 1'b1; end
      4'h5: begin acc_s = 1'b1; end
      4'h8: begin acc_s = 1'b1; acc_we_s = 1'b1; acc_wdata_s = valp_i; end
      4'h9, 4'hB: begin acc_s = 1'b1; acc_addr_s = vala_i; end
      4'hA: begin acc_s = 1'b1; acc_we_s = 1'b1; end
      default: begin acc_s = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    valm_d  = valm_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      // DONE returns to IDLE at the same edge, so it accepts start too.
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_DONE;
          if (stat_q != STAT_AOK) begin
            stat_d = stat_q;
          end else if (imem_error_i) begin
            stat_d = STAT_ADR;
          end else if (!instr_valid_i || (icode_i > 4'hB)) begin
            stat_d = STAT_INS;
          end else if (icode_i == 4'h0) begin
            stat_d = STAT_HLT;
          end else if (!acc_s) begin
            stat_d = stat_q;
          end else if (acc_addr_s > LAST_ADDR) begin
            stat_d = STAT_ADR;
          end else begin
            state_d = S_REQ;
            we_d    = acc_we_s;
            addr_d  = acc_addr_s;
            wdata_d = acc_wdata_s;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dmem.ack) begin
          state_d = S_DONE;
          cnt_d   = '0;
          if (dmem.err) begin
            stat_d = STAT_ADR;
          end else if (!we_q) begin
            valm_d = dmem.rdata;
          end else begin
            valm_d = valm_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          stat_d  = STAT_ADR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; req/busy/done follow the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      valm_q  <= 64'd0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stat_q  <= stat_d;
      valm_q  <= valm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == S_REQ);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  assign valm_o     = valm_q;
  assign stat_o     = stat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed, table-driven bench for memory_access with a hand-driven data
// memory; multi-cycle corner cases are separate sequences.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  icode = 4'h0;
  logic        instr_valid = 1'b1;
  logic        imem_error = 1'b0;
  logic [63:0] vale = 64'd0, vala = 64'd0, valp = 64'd0;
  logic [63:0] valm;
  logic [2:0]  stat;
  logic        busy, done;

  int checks = 0;
  int failures = 0;

  memory_access_if dmem_bus ();

  memory_access #(.MEM_BYTES(8192), .TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .icode_i(icode),
    .instr_valid_i(instr_valid), .imem_error_i(imem_error),
    .vale_i(vale), .vala_i(vala), .valp_i(valp),
    .valm_o(valm), .stat_o(stat), .busy_o(busy), .done_o(done),
    .dmem(dmem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  icode;
    logic        iv;
    logic        ie;
    logic [63:0] vale, vala, valp, rdata;
    logic        err;
    int          ack_at;
    int          exp_req;
    logic        exp_we;
    logic [63:0] exp_addr, exp_wdata, exp_valm;
    logic [2:0]  exp_stat;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic r, logic [3:0] ic, logic iv, logic ie,
                              logic [63:0] ve, logic [63:0] va, logic [63:0] vp,
                              logic [63:0] rd, logic er, int ack_at, int ereq,
                              logic ewe, logic [63:0] eaddr, logic [63:0] ewd,
                              logic [63:0] evm, logic [2:0] est, int elat);
    vec_t v;
    v.rst = r; v.icode = ic; v.iv = iv; v.ie = ie;
    v.vale = ve; v.vala = va; v.valp = vp; v.rdata = rd; v.err = er;
    v.ack_at = ack_at; v.exp_req = ereq; v.exp_we = ewe; v.exp_addr = eaddr;
    v.exp_wdata = ewd; v.exp_valm = evm; v.exp_stat = est; v.exp_lat = elat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    dmem_bus.ack = 1'b0; dmem_bus.err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int reqcnt;
    int lat;
    logic        seen_we;
    logic [63:0] seen_addr, seen_wdata;
    reqcnt = 0; lat = 0;
    seen_we = 1'b0; seen_addr = 64'd0; seen_wdata = 64'd0;
    if (v.rst) do_reset();
    @(negedge clk);
    icode = v.icode; instr_valid = v.iv; imem_error = v.ie;
    vale = v.vale; vala = v.vala; valp = v.valp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == 1) check($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
      if (done) begin
        lat = k;
      end else begin
        if (dmem_bus.req) begin
          reqcnt++;
          if (reqcnt == 1) begin
            seen_we = dmem_bus.we; seen_addr = dmem_bus.addr; seen_wdata = dmem_bus.wdata;
          end
          dmem_bus.ack   = (reqcnt == v.ack_at);
          dmem_bus.rdata = v.rdata;
          dmem_bus.err   = v.err;
        end else begin
          dmem_bus.ack = 1'b0;
        end
        @(negedge clk);
      end
    end
    dmem_bus.ack = 1'b0; dmem_bus.err = 1'b0;
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_req_cycles", idx), 64'(reqcnt), 64'(v.exp_req));
    check($sformatf("v%0d_stat", idx), 64'(stat), 64'(v.exp_stat));
    check($sformatf("v%0d_valM", idx), valm, v.exp_valm);
    if (v.exp_req > 0) begin
      check($sformatf("v%0d_we", idx), 64'(seen_we), 64'(v.exp_we));
      check($sformatf("v%0d_addr", idx), seen_addr, v.exp_addr);
      if (v.exp_we) check($sformatf("v%0d_wdata", idx), seen_wdata, v.exp_wdata);
    end
    @(negedge clk);
    check($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
    check($sformatf("v%0d_busy_end", idx), 64'(busy), 64'd0);
  endtask

  initial begin
    int reqcnt;
    int dones;

    dmem_bus.ack = 1'b0; dmem_bus.err = 1'b0; dmem_bus.rdata = 64'd0;

    //          rst  ic    iv    ie    valE                    valA          valP     rdata                   err  ack req we    addr          wdata     valM                    stat  lat
    vecs[0]  = mk(1'b1, 4'h5, 1'b1, 1'b0, 64'h100,             64'h0,        64'h0,   64'hDEADBEEF,           1'b0, 4, 4, 1'b0, 64'h100,  64'h0,  64'hDEADBEEF,         3'd1, 5);
    vecs[1]  = mk(1'b0, 4'h8, 1'b1, 1'b0, 64'h1F8,             64'h99,       64'h42,  64'h5555,               1'b0, 1, 1, 1'b1, 64'h1F8,  64'h42, 64'hDEADBEEF,         3'd1, 2);
    vecs[2]  = mk(1'b0, 4'hA, 1'b1, 1'b0, 64'h200,             64'h7,        64'h0,   64'h6666,               1'b0, 2, 2, 1'b1, 64'h200,  64'h7,  64'hDEADBEEF,         3'd1, 3);
    vecs[3]  = mk(1'b0, 4'hB, 1'b1, 1'b0, 64'h123,             64'h1FF8,     64'h0,   64'h1122334455667788,   1'b0, 1, 1, 1'b0, 64'h1FF8, 64'h0,  64'h1122334455667788, 3'd1, 2);
    vecs[4]  = mk(1'b0, 4'h9, 1'b1, 1'b0, 64'h1FFF0,           64'h40,       64'h0,   64'hCAFE,               1'b0, 3, 3, 1'b0, 64'h40,   64'h0,  64'hCAFE,             3'd1, 4);
    vecs[5]  = mk(1'b0, 4'h1, 1'b1, 1'b0, 64'h0,               64'h0,        64'h0,   64'h0,                  1'b0, 0, 0, 1'b0, 64'h0,    64'h0,  64'hCAFE,             3'd1, 1);
    vecs[6]  = mk(1'b0, 4'h5, 1'b1, 1'b0, 64'd8185,            64'h0,        64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'hCAFE,             3'd3, 1);
    vecs[7]  = mk(1'b0, 4'h5, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0,       64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'hCAFE,             3'd3, 1);
    vecs[8]  = mk(1'b0, 4'h4, 1'b1, 1'b0, 64'h10,              64'h3,        64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'hCAFE,             3'd3, 1);
    vecs[9]  = mk(1'b1, 4'hB, 1'b1, 1'b0, 64'h0,               64'h80,       64'h0,   64'h0,                  1'b0, 0, 16, 1'b0, 64'h80,  64'h0,  64'h0,                3'd3, 17);
    vecs[10] = mk(1'b1, 4'h5, 1'b1, 1'b0, 64'h8,               64'h0,        64'h0,   64'hBAD,                1'b1, 2, 2, 1'b0, 64'h8,    64'h0,  64'h0,                3'd3, 3);
    vecs[11] = mk(1'b1, 4'h0, 1'b1, 1'b1, 64'h0,               64'h0,        64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'h0,                3'd3, 1);
    vecs[12] = mk(1'b1, 4'h5, 1'b0, 1'b0, 64'h100,             64'h0,        64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'h0,                3'd4, 1);
    vecs[13] = mk(1'b1, 4'h0, 1'b1, 1'b0, 64'h0,               64'h0,        64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'h0,                3'd2, 1);
    vecs[14] = mk(1'b1, 4'hC, 1'b1, 1'b0, 64'h100,             64'h0,        64'h0,   64'h0,                  1'b0, 1, 0, 1'b0, 64'h0,    64'h0,  64'h0,                3'd4, 1);
    vecs[15] = mk(1'b1, 4'h4, 1'b1, 1'b0, 64'h30,              64'hAB,       64'h0,   64'h0,                  1'b1, 1, 1, 1'b1, 64'h30,   64'hAB, 64'h0,                3'd3, 2);

    // Reset values.
    do_reset();
    check("rst_valM", valm, 64'd0);
    check("rst_stat", 64'(stat), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_req", 64'(dmem_bus.req), 64'd0);
    check("rst_we", 64'(dmem_bus.we), 64'd0);
    check("rst_addr", dmem_bus.addr, 64'd0);
    check("rst_wdata", dmem_bus.wdata, 64'd0);

    // Ack while idle must be ignored.
    dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'hFFFF;
    repeat (3) @(negedge clk);
    dmem_bus.ack = 1'b0;
    check("idle_ack_valM", valm, 64'd0);
    check("idle_ack_done", 64'(done), 64'd0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

    // Reset in the 2nd REQ cycle, coincident with an ack.
    do_reset();
    @(negedge clk);
    icode = 4'h5; instr_valid = 1'b1; imem_error = 1'b0; vale = 64'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_req1", 64'(dmem_bus.req), 64'd1);
    @(negedge clk);
    check("mid_req2", 64'(dmem_bus.req), 64'd1);
    rst = 1'b1; dmem_bus.ack = 1'b1; dmem_bus.rdata = 64'h77;
    @(negedge clk);
    rst = 1'b0; dmem_bus.ack = 1'b0;
    check("mid_rst_req", 64'(dmem_bus.req), 64'd0);
    check("mid_rst_valM", valm, 64'd0);
    check("mid_rst_stat", 64'(stat), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);

    // Start pulses (halt) during REQ are ignored: one done, status stays AOK.
    do_reset();
    @(negedge clk);
    icode = 4'h5; vale = 64'h100; start = 1'b1;
    @(negedge clk);
    start = 1'b0; reqcnt = 0; dones = 0;
    for (int k = 1; k <= 25; k++) begin
      if (done) dones++;
      if (dmem_bus.req) begin
        reqcnt++;
        dmem_bus.ack = (reqcnt == 4); dmem_bus.rdata = 64'h1234; dmem_bus.err = 1'b0;
        start = (reqcnt <= 3); icode = 4'h0;
      end else begin
        dmem_bus.ack = 1'b0; start = 1'b0;
      end
      @(negedge clk);
    end
    check("busy_start_dones", 64'(dones), 64'd1);
    check("busy_start_stat", 64'(stat), 64'd1);
    check("busy_start_valM", valm, 64'h1234);

    // Back-to-back: start in the done cycle is accepted.
    do_reset();
    @(negedge clk);
    icode = 4'h1; start = 1'b1;
    @(negedge clk);
    check("b2b_done1", 64'(done), 64'd1);
    icode = 4'h4; vale = 64'h20; vala = 64'h5A; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_req", 64'(dmem_bus.req), 64'd1);
    check("b2b_done_low", 64'(done), 64'd0);
    check("b2b_wdata", dmem_bus.wdata, 64'h5A);
    dmem_bus.ack = 1'b1;
    @(negedge clk);
    dmem_bus.ack = 1'b0;
    check("b2b_done2", 64'(done), 64'd1);
    check("b2b_req_low", 64'(dmem_bus.req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
